// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Values above 10^DIGITS-1 saturate to all nines with ovf set.
module bin_to_bcd #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // Scratch holds every decimal digit a WIDTH-bit value can produce (0.302 > log10(2)).
    localparam int SD = (WIDTH * 302) / 1000 + 1;
    localparam int SW = 4 * SD;
    localparam int EW = (SW > 4 * DIGITS) ? SW : 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [63:0]         MAXV = pow10(DIGITS) - 64'd1;
    localparam logic [4*DIGITS-1:0] ALL9 = {DIGITS{4'h9}};

    function automatic logic [SW-1:0] add3_all(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        r = s;
        for (int i = 0; i < SD; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = s[4*i +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [4*DIGITS-1:0] fit(input logic [EW-1:0] e);
        return e[4*DIGITS-1:0];
    endfunction

    typedef enum logic [0:0] {IDLE = 1'b0, CONV = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      shift_q, shift_d;
    logic [SW-1:0]         scr_q, scr_d;
    logic [SW-1:0]         scr_add_s;
    logic [SW-1:0]         scr_shift_s;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ovfp_q, ovfp_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  ovf_q, ovf_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Next-state and output logic for the IDLE/CONV controller and datapath.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        scr_d       = scr_q;
        cnt_d       = cnt_q;
        ovfp_d      = ovfp_q;
        bcd_d       = bcd_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;
        scr_add_s   = add3_all(scr_q);
        scr_shift_s = {scr_add_s[SW-2:0], shift_q[WIDTH-1]};
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = bin;
                    scr_d   = '0;
                    cnt_d   = '0;
                    ovfp_d  = (64'(bin) > MAXV);
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                scr_d   = scr_shift_s;
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ovf_d   = ovfp_q;
                    bcd_d   = ovfp_q ? ALL9 : fit(EW'(scr_shift_s));
                end else begin
                    state_d = CONV;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == CONV);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            ovfp_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            ovfp_q  <= ovfp_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bcd  = bcd_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed and randomized checks of bin_to_bcd with default parameters.
module tb_bin_to_bcd;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        busy;
    logic        done;
    logic        ovf;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bin_to_bcd #(.WIDTH(14), .DIGITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic start_conv(input logic [13:0] v);
        start = 1'b1;
        bin   = v;
        step();
        start = 1'b0;
    endtask

    // Waits (bounded) for done; lat counts edges since the edge that sampled start.
    task automatic wait_done(input int lat0, output int lat, output bit stable);
        logic [15:0] b0;
        b0     = bcd;
        lat    = lat0;
        stable = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            if (bcd !== b0 || busy !== 1'b1) stable = 1'b0;
            step();
            lat++;
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (done === 1'b1) n++;
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int          t;
        if (v > 9999) return 16'h9999;
        r = 16'h0000;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    initial begin
        int          lat;
        bit          st;
        int          nd;
        int          v;
        logic [15:0] exp_b;

        reset = 1'b1;
        start = 1'b0;
        bin   = 14'd0;
        repeat (3) step();
        chk("reset_bcd",  32'(bcd),  32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_ovf",  32'(ovf),  32'h0);
        reset = 1'b0;
        step();

        // 1234: busy 14 cycles, then single done
        start_conv(14'd1234);
        chk("1234_busy_start", 32'(busy), 32'h1);
        wait_done(0, lat, st);
        chk("1234_latency", 32'(lat), 32'd14);
        chk("1234_bcd", 32'(bcd), 32'h1234);
        chk("1234_ovf", 32'(ovf), 32'h0);
        chk("1234_busy_at_done", 32'(busy), 32'h0);
        chk("1234_stable_conv", 32'(st), 32'h1);
        step();
        chk("1234_done_one_cycle", 32'(done), 32'h0);
        chk("1234_bcd_held", 32'(bcd), 32'h1234);

        // back-to-back 0 then 9999, second start in the done cycle
        start_conv(14'd0);
        wait_done(0, lat, st);
        chk("zero_latency", 32'(lat), 32'd14);
        chk("zero_bcd", 32'(bcd), 32'h0000);
        chk("zero_ovf", 32'(ovf), 32'h0);
        start_conv(14'd9999);
        chk("b2b_busy", 32'(busy), 32'h1);
        wait_done(0, lat, st);
        chk("9999_latency", 32'(lat), 32'd14);
        chk("9999_bcd", 32'(bcd), 32'h9999);
        chk("9999_ovf", 32'(ovf), 32'h0);
        step();

        // overflow then normal value, plus the 10000 boundary
        start_conv(14'd12000);
        wait_done(0, lat, st);
        chk("12000_bcd", 32'(bcd), 32'h9999);
        chk("12000_ovf", 32'(ovf), 32'h1);
        chk("12000_latency", 32'(lat), 32'd14);
        step();
        start_conv(14'd42);
        wait_done(0, lat, st);
        chk("42_bcd", 32'(bcd), 32'h0042);
        chk("42_ovf", 32'(ovf), 32'h0);
        step();
        start_conv(14'd10000);
        wait_done(0, lat, st);
        chk("10000_bcd", 32'(bcd), 32'h9999);
        chk("10000_ovf", 32'(ovf), 32'h1);
        step();

        // start while busy is ignored
        start_conv(14'd5678);
        repeat (4) step();
        start = 1'b1;
        bin   = 14'd1111;
        step();
        start = 1'b0;
        wait_done(5, lat, st);
        chk("5678_latency", 32'(lat), 32'd14);
        chk("5678_bcd", 32'(bcd), 32'h5678);
        chk("5678_ovf", 32'(ovf), 32'h0);
        count_done(20, nd);
        chk("ignored_start_no_done", 32'(nd), 32'd0);
        chk("5678_bcd_held", 32'(bcd), 32'h5678);

        // reset mid-conversion aborts with no done
        start_conv(14'd4321);
        repeat (6) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_bcd", 32'(bcd), 32'h0);
        count_done(20, nd);
        chk("abort_no_done", 32'(nd), 32'd0);
        start_conv(14'd7);
        wait_done(0, lat, st);
        chk("7_latency", 32'(lat), 32'd14);
        chk("7_bcd", 32'(bcd), 32'h0007);
        chk("7_ovf", 32'(ovf), 32'h0);
        step();

        // randomized values against a divide/modulo reference
        for (int k = 0; k < 1000; k++) begin
            v     = int'($urandom_range(0, 16383));
            exp_b = ref_bcd(v);
            start_conv(14'(v));
            wait_done(0, lat, st);
            chk("rand_latency", 32'(lat), 32'd14);
            chk("rand_bcd", 32'(bcd), 32'(exp_b));
            chk("rand_ovf", 32'(ovf), (v > 9999) ? 32'h1 : 32'h0);
            step();
            chk("rand_done_pulse", 32'(done), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd.md
BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 Parameter WIDTH, default 14: binary input width in bits.
REQ-002 Parameter DIGITS, default 4: number of BCD output digits.
REQ-003 clk  input  1: single clock; all logic on rising edge.
REQ-004 reset  input  1: synchronous reset, active-high.
REQ-005 start  input  1: request conversion of bin; sampled on rising clk edge.
REQ-006 bin  input  WIDTH: unsigned binary value; captured only on an accepted start.
REQ-007 bcd  output  4*DIGITS: result digits; digit i at bits [4i+3:4i], digit 0 least significant; each digit 0-9, feeds one 7-segment decoder per digit.
REQ-008 busy  output  1: high while a conversion is in progress.
REQ-009 done  output  1: one-cycle pulse marking a new valid bcd/ovf.
REQ-010 ovf  output  1: last result saturated because bin exceeded 10^DIGITS-1.

Function
REQ-011 Conversion SHALL use sequential shift-and-add-3 (double dabble), one bit per clock cycle.
REQ-012 FSM states SHALL be IDLE and CONV only; reset state IDLE.
REQ-013 IDLE with start=1 at edge k: capture bin, clear BCD scratch, bit counter=0, go to CONV; busy=1 after edge k.
REQ-014 In IDLE with start=0: no state change; outputs held.
REQ-015 CONV, each edge: every scratch digit >=5 gets +3, then {scratch, shift reg} shifts left by 1; counter increments.
REQ-016 The edge completing iteration WIDTH (edge k+WIDTH) SHALL load bcd and ovf, set done=1, busy=0, return to IDLE.
REQ-017 Latency: done first visible exactly WIDTH edges after the edge that sampled start (14 for defaults).
REQ-018 done SHALL be high for exactly one cycle per accepted start.
REQ-019 busy and done SHALL never be high in the same cycle.
REQ-020 start while busy=1 SHALL be ignored; in-flight conversion and its bin unaffected.
REQ-021 start high in the cycle done is high SHALL be accepted (back-to-back, no idle gap).
REQ-022 Overflow: if captured bin > 10^DIGITS-1, at completion bcd SHALL be all digits 9 and ovf=1; otherwise ovf=0. Latency unchanged.
REQ-023 Scratch register SHALL be wide enough that no intermediate digit exceeds 4 bits for any WIDTH-bit input.
REQ-024 bcd and ovf SHALL change only on the completion edge; held stable between done pulses and throughout CONV.
REQ-025 No output digit SHALL ever be outside 0-9.

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE, bcd=0, ovf=0, busy=0, done=0, counter=0.
REQ-027 reset SHALL take priority over start and over any in-flight conversion.
REQ-028 Reset during CONV SHALL abort with no done pulse; bcd keeps reset value 0.
REQ-029 First start after reset released SHALL be accepted normally.

Verification
REQ-030 bin=1234, start 1 cycle -> busy 14 cycles, then done 1 cycle, bcd=16'h1234, ovf=0.
REQ-031 bin=0 then bin=9999 back-to-back (second start during done cycle) -> bcd=16'h0000 then 16'h9999, 14 cycles apart, ovf=0 both.
REQ-032 bin=12000 -> bcd=16'h9999, ovf=1; following bin=42 -> bcd=16'h0042, ovf=0.
REQ-033 start bin=5678, start again at cycle 5 with bin=1111 -> single done, bcd=16'h5678; second start ignored.
REQ-034 start bin=4321, reset at cycle 7 -> no done, busy=0, bcd=0; new start bin=7 -> bcd=16'h0007 after 14 cycles.
REQ-035 Random bin 0-16383, 1000 iterations against reference model -> exact bcd/ovf match, done latency always 14, one done per accepted start.
